div_ctrl: RTL and testbench

Run-time controller for the lane clock divider. Holds the active divide ratio M, accepts new ratios through a valid/ready handshake and applies them only at a counter wrap boundary, so that the divided clock never shows a runt phase. Produces the divided clock, a one-cycle wrap strobe and the phase count, and sits between the configuration logic and the serializer/deserializer clocking.

---
 rtl/div_ctrl_pkg.sv | 17 +
 rtl/div_ctrl_mod_counter.sv | 24 ++
 rtl/div_ctrl.sv | 91 +++++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the lane clock divider controller.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int unsigned M_MIN = 2;

   // Counter width able to hold the value m_max.
   function automatic int unsigned cnt_width(input int unsigned m_max);
      return $clog2(m_max + 1);
   endfunction

endpackage

// File: rtl/div_ctrl_mod_counter.sv
// Modulo counter with run enable, synchronous clear and terminal-count flag.
module mod_counter #(
   parameter int unsigned W = 5
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] modulus,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   assign wrap = (cnt == modulus - W'(1));

   always_ff @(posedge clk_in) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Lane clock divider controller: holds the active ratio and swaps in new
// ratios only at a period boundary so the divided clock never shows a runt.
module div_ctrl
   import div_pkg::*;
#(
   parameter  int unsigned M_MAX     = 16,
   parameter  int unsigned M_DEFAULT = 4,
   localparam int unsigned W         = cnt_width(M_MAX)
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic         enable,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_m,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         clk_out,
   output logic         tick,
   output logic [W-1:0] phase,
   output logic         busy
);

   state_t       state;
   logic [W-1:0] m_cur;
   logic [W-1:0] m_nxt;
   logic [W-1:0] cnt;
   logic         wrap;
   logic         accept;
   logic         legal;
   logic         cnt_en;
   logic         cnt_clr;

   assign accept  = cfg_valid && cfg_ready;
   assign legal   = (cfg_m >= W'(M_MIN)) && (cfg_m <= W'(M_MAX));
   assign cnt_en  = (state != IDLE);
   assign cnt_clr = (state == IDLE) || !enable;

   mod_counter #(.W(W)) u_cnt (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (cnt_en),
      .clr     (cnt_clr),
      .modulus (m_cur),
      .cnt     (cnt),
      .wrap    (wrap)
   );

   // Ratio registers and control FSM; dropping enable commits any pending ratio.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state   <= IDLE;
         m_cur   <= W'(M_DEFAULT);
         m_nxt   <= W'(M_DEFAULT);
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept && !legal;
         case (state)
            IDLE: begin
               if (accept && legal) m_cur <= cfg_m;
               if (enable) state <= RUN;
            end
            RUN: begin
               if (!enable) begin
                  state <= IDLE;
                  if (accept && legal) m_cur <= cfg_m;
               end else if (accept && legal) begin
                  m_nxt <= cfg_m;
                  state <= PEND;
               end
            end
            PEND: begin
               if (!enable) begin
                  state <= IDLE;
                  m_cur <= m_nxt;
               end else if (wrap) begin
                  m_cur <= m_nxt;
                  state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg_ready = (state != PEND);
   assign busy      = (state == PEND);
   assign phase     = cnt;
   assign tick      = (state != IDLE) && wrap;
   assign clk_out   = (state != IDLE) && (cnt >= (m_cur >> 1));

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl against a period-level reference model.
module tb_div_ctrl;

   localparam int unsigned W = 5;

   logic         clk_in = 1'b0;
   logic         reset;
   logic         enable;
   logic         cfg_valid;
   logic [W-1:0] cfg_m;
   logic         cfg_ready;
   logic         cfg_err;
   logic         clk_out;
   logic         tick;
   logic [W-1:0] phase;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Reference model: running flag, active ratio, optional pending ratio,
   // position inside the current period, expected error pulse.
   int run, ratio, pend_valid, pend_val, pos, err_exp;

   div_ctrl #(.M_MAX(16), .M_DEFAULT(4)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_m     (cfg_m),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .phase     (phase),
      .busy      (busy)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      run = 0; ratio = 4; pend_valid = 0; pend_val = 0; pos = 0; err_exp = 0;
   endtask

   task automatic compare_outputs();
      chk("phase",     int'(phase),     run ? pos : 0);
      chk("tick",      int'(tick),      int'(run != 0 && pos == ratio - 1));
      chk("clk_out",   int'(clk_out),   int'(run != 0 && pos >= ratio / 2));
      chk("busy",      int'(busy),      pend_valid);
      chk("cfg_ready", int'(cfg_ready), int'(pend_valid == 0));
      chk("cfg_err",   int'(cfg_err),   err_exp);
   endtask

   task automatic model_update(input bit r, input bit en, input bit v, input int m);
      int acc, legal, at_end;
      if (r) begin
         model_reset();
         return;
      end
      acc     = int'(v && pend_valid == 0);
      legal   = int'(m >= 2 && m <= 16);
      err_exp = int'(acc != 0 && legal == 0);
      if (run == 0) begin
         if (acc != 0 && legal != 0) ratio = m;
         if (en) run = 1;
         pos = 0;
      end else if (!en) begin
         if (pend_valid != 0) ratio = pend_val;
         else if (acc != 0 && legal != 0) ratio = m;
         run = 0; pos = 0; pend_valid = 0;
      end else begin
         at_end = int'(pos == ratio - 1);
         pos = (at_end != 0) ? 0 : pos + 1;
         if (pend_valid != 0 && at_end != 0) begin
            ratio = pend_val;
            pend_valid = 0;
         end else if (acc != 0 && legal != 0) begin
            pend_valid = 1;
            pend_val = m;
         end
      end
   endtask

   // One clock: check outputs, drive inputs, advance the model on the edge.
   task automatic step(input bit r, input bit en, input bit v, input int m);
      @(negedge clk_in);
      compare_outputs();
      reset = r; enable = en; cfg_valid = v; cfg_m = W'(m);
      @(posedge clk_in);
      model_update(r, en, v, m & 31);
   endtask

   task automatic idle_run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
   endtask

   initial begin
      logic [3:0] pat;
      int guard;
      reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_m = '0;
      model_reset();
      repeat (2) @(posedge clk_in);

      // Reset state, then M=4 waveform
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         #1 pat[i] = clk_out;
         step(1'b0, 1'b1, 1'b0, 0);
      end
      chk("m4_clk_pattern", int'(pat), 4'b1100);

      // Ratio 6 offered at phase 1
      step(1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b1, 6);
      idle_run(16);

      // Back to 4, then offer 5 exactly in the tick cycle
      step(1'b0, 1'b1, 1'b1, 4);
      idle_run(14);
      guard = 0;
      while (pos != ratio - 1 && guard < 20) begin
         step(1'b0, 1'b1, 1'b0, 0);
         guard++;
      end
      chk("tick_align_timeout", int'(guard < 20), 1);
      step(1'b0, 1'b1, 1'b1, 5);
      idle_run(16);

      // Illegal ratios below and above range
      step(1'b0, 1'b1, 1'b1, 1);
      idle_run(8);
      step(1'b0, 1'b1, 1'b1, 17);
      idle_run(8);
      step(1'b0, 1'b1, 1'b1, 0);
      idle_run(6);

      // Drop enable while pending 8, then re-enable
      step(1'b0, 1'b1, 1'b1, 8);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      idle_run(20);

      // Reset in the middle of a pending change
      step(1'b0, 1'b1, 1'b1, 3);
      step(1'b1, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 0);
      idle_run(10);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, en, v;
         int m;
         r  = ($urandom % 200) == 0;
         en = ($urandom % 20) != 0;
         v  = ($urandom % 5) == 0;
         m  = (($urandom % 10) == 0) ? int'($urandom % 32) : int'($urandom % 18);
         step(r, en, v, m);
      end
      step(1'b0, 1'b1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
